// File: rtl/mult_pipe_vr.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pipe_vr
//  Purpose  : Parametrised pipelined multiplier with valid/ready handshake.
//             Every operand pair carries its own signedness select (TC) and
//             sideband tag. The product is the full A_width+B_width bits.
//             The pipeline collapses bubbles and honours backpressure.
//             flush clears the pipeline synchronously. inflight reports how
//             many items the pipeline currently holds.
//  Ports    : CLK, RST_N         clock, asynchronous active-low reset
//             in_valid/in_ready  input handshake for A, B, TC, in_tag
//             flush              synchronous clear of all stage valid bits
//             out_valid/out_ready output handshake for PRODUCT, out_tag
//             inflight           number of valid items held in the pipeline
//  Revision : 1.0  initial release
// ============================================================================
module mult_pipe_vr #(
    parameter int A_width    = 8,
    parameter int B_width    = 8,
    parameter int NUM_STAGES = 5,
    parameter int TAG_width  = 4
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [A_width-1:0]                A,
    input  logic [B_width-1:0]                B,
    input  logic                              TC,
    input  logic [TAG_width-1:0]              in_tag,
    input  logic                              flush,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [A_width+B_width-1:0]        PRODUCT,
    output logic [TAG_width-1:0]              out_tag,
    output logic [$clog2(NUM_STAGES+1)-1:0]   inflight
);

    localparam int c_PW = A_width + B_width;
    localparam int c_CW = $clog2(NUM_STAGES + 1);

    // ------------------------------------------------------------------
    // Per-stage control
    // ------------------------------------------------------------------
    logic [NUM_STAGES-1:0]  r_valid;
    logic [NUM_STAGES:0]    w_ready;
    logic [NUM_STAGES-1:0]  w_up_valid;
    logic [TAG_width-1:0]   r_tag      [NUM_STAGES];
    logic [TAG_width-1:0]   w_up_tag   [NUM_STAGES];
    logic                   w_in_xfer;
    logic                   w_out_xfer;
    logic [c_PW-1:0]        w_ext_a;
    logic [c_PW-1:0]        w_ext_b;
    logic [c_CW-1:0]        r_count;

    // A stage is ready when it is empty or when the stage ahead is ready.
    // Unrolled, that is: out_ready, or any stage from here to the output
    // is empty. Writing it in the flat form keeps each ready bit a direct
    // function of registers and out_ready with no bit-to-bit chain.
    assign w_ready[NUM_STAGES] = out_ready;

    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_ready
        assign w_ready[gi] = out_ready | ~(&r_valid[NUM_STAGES-1:gi]);
    end

    assign in_ready   = w_ready[0] & ~flush;
    assign w_in_xfer  = in_valid & in_ready;
    assign out_valid  = r_valid[NUM_STAGES-1];
    assign w_out_xfer = out_valid & out_ready;
    assign out_tag    = r_tag[NUM_STAGES-1];
    assign inflight   = r_count;

    // Upstream view of each stage: stage 0 sees the input port, every
    // other stage sees its predecessor.
    assign w_up_valid[0] = w_in_xfer;
    assign w_up_tag[0]   = in_tag;

    for (genvar gi = 1; gi < NUM_STAGES; gi++) begin : g_link
        assign w_up_valid[gi] = r_valid[gi-1];
        assign w_up_tag[gi]   = r_tag[gi-1];
    end

    // Extending both operands to the full product width lets a single
    // c_PW x c_PW multiply, truncated to c_PW bits, give the exact result
    // for both the signed and the unsigned case. The true product always
    // fits in c_PW bits, so the truncation never loses information.
    assign w_ext_a = {{B_width{TC & A[A_width-1]}}, A};
    assign w_ext_b = {{A_width{TC & B[B_width-1]}}, B};

    // ------------------------------------------------------------------
    // Valid bits and tags
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_valid <= '0;
        end else if (flush) begin
            // Flush clears every stage, including stalled ones. Any output
            // transfer in this cycle has already been taken by the consumer.
            r_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (w_ready[i]) begin
                    r_valid[i] <= w_up_valid[i];
                end
            end
        end
    end

    // Tags only move with real data so a stalled or empty stage keeps its
    // last value and does not toggle needlessly.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (w_ready[i] & w_up_valid[i]) begin
                    r_tag[i] <= w_up_tag[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Occupancy counter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_in_xfer & ~w_out_xfer) begin
            r_count <= r_count + 1'b1;
        end else if (~w_in_xfer & w_out_xfer) begin
            r_count <= r_count - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    if (NUM_STAGES == 1) begin : g_single
        // One register slice: the multiply sits in front of it.
        logic [c_PW-1:0] r_prod;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_prod <= '0;
            end else if (w_ready[0] & w_in_xfer) begin
                r_prod <= w_ext_a * w_ext_b;
            end
        end

        assign PRODUCT = r_prod;
    end else begin : g_multi
        // Stage 0 registers the extended operands so the multiplier starts
        // from clean flops instead of the producer's logic. Stage 1 holds
        // the product. The remaining stages are plain delay registers;
        // register retiming may move the multiplier logic into them.
        logic [c_PW-1:0] r_op_a;
        logic [c_PW-1:0] r_op_b;
        logic [c_PW-1:0] w_mul;
        logic [c_PW-1:0] r_prod [1:NUM_STAGES-1];

        assign w_mul = r_op_a * r_op_b;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_op_a <= '0;
                r_op_b <= '0;
            end else if (w_ready[0] & w_in_xfer) begin
                r_op_a <= w_ext_a;
                r_op_b <= w_ext_b;
            end
        end

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                for (int i = 1; i < NUM_STAGES; i++) begin
                    r_prod[i] <= '0;
                end
            end else begin
                if (w_ready[1] & r_valid[0]) begin
                    r_prod[1] <= w_mul;
                end
                for (int i = 2; i < NUM_STAGES; i++) begin
                    if (w_ready[i] & r_valid[i-1]) begin
                        r_prod[i] <= r_prod[i-1];
                    end
                end
            end
        end

        assign PRODUCT = r_prod[NUM_STAGES-1];
    end

endmodule
`default_nettype wire

// File: doc/mult_pipe_vr.md
Name: mult_pipe_vr

Overview:
- Parametrised pipelined multiplier; successor to the fixed 5-stage multiplier.
- Pipeline depth, operand widths and a sideband tag width are configurable.
- Signedness (TC) is selected per operand pair and travels with the data.
- Adds a valid/ready handshake with backpressure, bubble collapse, synchronous flush and an in-flight occupancy count.
- Sits between streaming datapath producers and consumers that can stall.

Parameters:
- A_width, 8, width of operand A (>=1).
- B_width, 8, width of operand B (>=1).
- NUM_STAGES, 5, register stages from input to output (>=1).
- TAG_width, 4, width of the sideband tag carried alongside each product (>=1).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- in_valid  input  1  A, B, TC and tag are valid this cycle.
- in_ready  output  1  block accepts an operand pair this cycle.
- A  input  A_width  multiplicand.
- B  input  B_width  multiplier.
- TC  input  1  0 = unsigned, 1 = two's-complement signed; applies to both operands.
- in_tag  input  TAG_width  user sideband value, returned unchanged with the product.
- flush  input  1  synchronous pipeline clear.
- out_valid  output  1  PRODUCT and out_tag are valid.
- out_ready  input  1  consumer accepts the output this cycle.
- PRODUCT  output  A_width+B_width  full-width product.
- out_tag  output  TAG_width  tag of the product currently on PRODUCT.
- inflight  output  $clog2(NUM_STAGES+1)  number of valid items held in the pipeline.

Behaviour:
- Reset (RST_N low, asynchronous): all stage valid bits, PRODUCT, out_tag and inflight go to 0; out_valid = 0. in_ready is 1 once reset is released.
- Transfers:
  - Input transfer when in_valid & in_ready at a rising edge.
  - Output transfer when out_valid & out_ready at a rising edge.
- Stage handshake, for stages i = 0..NUM_STAGES-1 (0 nearest the input):
  - ready[i] = ~valid[i] | ready[i+1], with ready[NUM_STAGES] = out_ready.
  - in_ready = ready[0] & ~flush.
  - out_valid = valid[NUM_STAGES-1].
  - Stage i loads from stage i-1 (or from the input for i = 0) when ready[i]. Its valid bit takes the upstream valid (in_valid & in_ready for stage 0).
  - Bubbles collapse: an empty stage accepts data even while downstream stalls.
- Latency: exactly NUM_STAGES cycles from input transfer to out_valid, with no stall.
- Throughput: one transfer per cycle when out_ready is held 1.
- Ordering: strict FIFO order. No item is dropped or duplicated under any out_ready pattern.
- Arithmetic: PRODUCT equals A*B over the full A_width+B_width bits.
  - TC = 1: both operands are sign-extended and the result is two's complement.
  - TC = 0: both operands are zero-extended.
  - No truncation or overflow.
  - TC and in_tag are captured with the operands; changing TC later does not affect in-flight items.
  - The multiply may be split across stages internally. Only the output timing and value are specified.
- Output stability: while out_valid & ~out_ready, PRODUCT and out_tag hold their values.
- inflight:
  - Increments by 1 on an input-only transfer.
  - Decrements by 1 on an output-only transfer.
  - Unchanged when input and output transfer together, or when neither does.
  - Range is 0..NUM_STAGES.
- Full pipeline: all stages valid and out_ready = 0 gives in_ready = 0. With out_ready = 1, a full pipeline still accepts one input per cycle.
- Flush:
  - flush = 1 forces in_ready = 0, so any in_valid is not accepted.
  - At the next edge all valid bits and inflight clear.
  - An output transfer that occurs in the flush cycle completes normally.
  - Flush wins over any simultaneous load.
- Reset mid-operation: all in-flight items are discarded. No out_valid appears after reset until new inputs have traversed NUM_STAGES cycles.
- NUM_STAGES = 1: a single register slice with the same rules.

Test Plan:
- Unsigned, 8x8, 5 stages: A=0xFF, B=0xFF, TC=0, tag=3 -> out_valid exactly 5 cycles later with PRODUCT=0xFE01, out_tag=3.
- Signed multiplies:
  - A=0x80, B=0x7F, TC=1 -> PRODUCT=0xC080 (-16256).
  - A=0xFF, B=0xFF, TC=1 -> 0x0001.
  - Back-to-back with alternating TC, each result is correct.
- Backpressure: stream 10 pairs (A=i, B=i+1), out_ready=0 from cycle 3.
  - Result: in_ready drops when inflight=5.
  - On out_ready=1, outputs i*(i+1) in order with no loss and no duplication.
  - PRODUCT is stable while stalled.
- Bubble collapse: single item in, out_ready=0, then a second item 3 cycles later.
  - Result: the second item sits directly behind the first; inflight=2.
  - On release, two consecutive outputs.
- Flush: 4 items in flight, assert flush for 1 cycle with in_valid=1.
  - Result: in_ready=0 during flush.
  - Next cycle inflight=0, out_valid=0; no stale outputs afterwards.
- Reset mid-stream: deassert RST_N asynchronously between edges with 3 items in flight.
  - Result: out_valid=0, PRODUCT=0 and inflight=0 immediately.
  - After release, a new A=7, B=6 gives 42 at latency 5.
